// File: rtl/greedy_mono_stack_if.sv
// Stream bundle for greedy_mono_stack: element input channel and result drain channel.
interface greedy_mono_stack_if #(
    parameter int DATA_W = 4
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/greedy_mono_stack.sv
// Streaming monotonic stack: keeps the lexicographically largest K-element
// subsequence of an input stream using at most a fixed number of drops.
module greedy_mono_stack #(
    parameter  int DATA_W  = 4,
    parameter  int MAX_CAP = 16,
    parameter  int LEN_W   = 8,
    localparam int SP_W    = $clog2(MAX_CAP) + 1,
    localparam int ADDR_W  = $clog2(MAX_CAP)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [SP_W-1:0]     keep_count,
    input  logic [LEN_W-1:0]    drop_budget,
    greedy_mono_stack_if.slave  strm,
    output logic                busy,
    output logic                error
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_CMP    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SP_W-1:0]    k_q, k_d;
    logic [LEN_W-1:0]   drops_q, drops_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic [SP_W-1:0]    rd_q, rd_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic               hlast_q, hlast_d;
    logic               error_q, error_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               busy_q, busy_d;

    logic [DATA_W-1:0]  data_q [MAX_CAP];
    logic [DATA_W-1:0]  top_s;
    logic               pop_s;
    logic               push_s;

    // Strict less-than: equal values are never popped, so ties keep the older element.
    assign top_s = data_q[ADDR_W'(sp_q - SP_W'(1))];
    assign pop_s = (state_q == ST_CMP) && (sp_q != SP_W'(0)) &&
                   (top_s < hold_q) && (drops_q != LEN_W'(0));

    assign strm.in_ready  = in_ready_q;
    assign strm.out_valid = out_valid_q;
    assign strm.out_last  = out_last_q;
    assign strm.out_data  = data_q[ADDR_W'(rd_q)];
    assign busy           = busy_q;
    assign error          = error_q;

    // Next-state, stack pointer, drop budget and output-flag computation.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        drops_d = drops_q;
        sp_d    = sp_q;
        rd_d    = rd_q;
        hold_d  = hold_q;
        hlast_d = hlast_q;
        error_d = error_q;
        push_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((keep_count == SP_W'(0)) || (keep_count > SP_W'(MAX_CAP))) begin
                        error_d = 1'b1;
                    end else begin
                        k_d     = keep_count;
                        drops_d = drop_budget;
                        sp_d    = SP_W'(0);
                        rd_d    = SP_W'(0);
                        error_d = 1'b0;
                        state_d = ST_ACCEPT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCEPT: begin
                if (strm.in_valid && in_ready_q) begin
                    hold_d  = strm.in_data;
                    hlast_d = strm.in_last;
                    state_d = ST_CMP;
                end else begin
                    state_d = ST_ACCEPT;
                end
            end

            ST_CMP: begin
                if (pop_s) begin
                    sp_d    = sp_q - SP_W'(1);
                    drops_d = drops_q - LEN_W'(1);
                end else begin
                    if (sp_q < k_q) begin
                        push_s = 1'b1;
                        sp_d   = sp_q + SP_W'(1);
                    end else if (drops_q != LEN_W'(0)) begin
                        drops_d = drops_q - LEN_W'(1);
                    end else begin
                        error_d = 1'b1;
                    end
                    if (hlast_q) begin
                        // Unused drops at end of stream mean it was shorter than declared.
                        error_d = error_d | (drops_d != LEN_W'(0));
                        rd_d    = SP_W'(0);
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end
            end

            ST_DRAIN: begin
                if (sp_q == SP_W'(0)) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (out_valid_q && strm.out_ready) begin
                    if (rd_q == (sp_q - SP_W'(1))) begin
                        sp_d    = SP_W'(0);
                        rd_d    = SP_W'(0);
                        state_d = ST_IDLE;
                    end else begin
                        rd_d = rd_q + SP_W'(1);
                    end
                end else begin
                    rd_d = rd_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_ACCEPT);
        out_valid_d = (state_d == ST_DRAIN) && (sp_d != SP_W'(0));
        out_last_d  = out_valid_d && (rd_d == (sp_d - SP_W'(1)));
        busy_d      = (state_d != ST_IDLE);
    end

    // Control and output-flag registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_q         <= SP_W'(0);
            drops_q     <= LEN_W'(0);
            sp_q        <= SP_W'(0);
            rd_q        <= SP_W'(0);
            hold_q      <= DATA_W'(0);
            hlast_q     <= 1'b0;
            error_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            drops_q     <= drops_d;
            sp_q        <= sp_d;
            rd_q        <= rd_d;
            hold_q      <= hold_d;
            hlast_q     <= hlast_d;
            error_q     <= error_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    // Stack storage; contents are deliberately left unreset.
    always_ff @(posedge clock) begin
        if (push_s) begin
            data_q[ADDR_W'(sp_q)] <= hold_q;
        end
    end

endmodule

// File: tb/tb_greedy_mono_stack.sv
// Bench for greedy_mono_stack: directed vector table, corner sequences and
// randomized streams checked against a queue-based greedy reference model.
module tb_greedy_mono_stack;
    localparam int DW  = 4;
    localparam int LW  = 8;
    localparam int SPW = 5;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic [SPW-1:0] keep_count;
    logic [LW-1:0]  drop_budget;
    logic           busy;
    logic           error;

    greedy_mono_stack_if #(.DATA_W(DW)) s ();

    greedy_mono_stack dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .keep_count  (keep_count),
        .drop_budget (drop_budget),
        .strm        (s),
        .busy        (busy),
        .error       (error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int nerr = 0;
    int nchk = 0;

    logic [3:0] in_q[$];
    logic [3:0] out_q[$];
    bit         last_q[$];
    int         acc_q[$];
    logic [3:0] e_q[$];
    logic [3:0] m_out[$];
    int         m_pops[$];

    typedef struct packed {
        logic [4:0]  k;
        logic [7:0]  drop;
        logic [4:0]  len;
        logic [63:0] ins;
        logic [4:0]  olen;
        logic [63:0] outs;
        logic        err;
        logic [1:0]  rmode;
        logic        abort;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: the greedy rule applied to a queue, counting pops per element.
    function automatic void model(input int k, input int drop, output bit err);
        int d;
        int p;
        d = drop;
        err = 1'b0;
        m_out.delete();
        m_pops.delete();
        foreach (in_q[i]) begin
            p = 0;
            while (m_out.size() > 0 && m_out[$] < in_q[i] && d > 0) begin
                void'(m_out.pop_back());
                d--;
                p++;
            end
            if (m_out.size() < k) m_out.push_back(in_q[i]);
            else if (d > 0) d--;
            else err = 1'b1;
            m_pops.push_back(p);
        end
        if (d != 0) err = 1'b1;
    endfunction

    task automatic run_stream(input int k, input int drop, input int rmode,
                              input bit abort, output bit err_o);
        int t;
        int ph;
        bit stalled;
        logic [3:0] held;
        out_q.delete();
        last_q.delete();
        acc_q.delete();
        err_o = 1'b0;
        held = 4'd0;
        @(negedge clock);
        start = 1'b1;
        keep_count = SPW'(k);
        drop_budget = LW'(drop);
        @(negedge clock);
        start = 1'b0;
        foreach (in_q[i]) begin
            s.in_valid = 1'b1;
            s.in_data  = in_q[i];
            s.in_last  = (i == in_q.size() - 1);
            t = 0;
            while (!s.in_ready && t < 100) begin
                @(negedge clock);
                t++;
            end
            if (!s.in_ready) begin
                nchk++; nerr++;
                $display("FAIL in_ready_timeout: got 0 expected 1 at element %0d", i);
                s.in_valid = 1'b0;
                return;
            end
            acc_q.push_back(cyc);
            @(negedge clock);
        end
        s.in_valid = 1'b0;
        s.in_last  = 1'b0;
        t = 0;
        ph = 0;
        stalled = 1'b0;
        while (busy && t < 400) begin
            if (abort && s.out_valid && out_q.size() >= 1) begin
                s.out_ready = 1'b0;
                err_o = error;
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                chk("abort_out_valid", int'(s.out_valid), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_error", int'(error), 0);
                repeat (3) @(negedge clock);
                chk("abort_quiet", int'(s.out_valid), 0);
                return;
            end
            case (rmode)
                0:       s.out_ready = 1'b1;
                1:       s.out_ready = 1'($urandom_range(0, 1));
                default: s.out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
            endcase
            ph++;
            if (stalled) begin
                chk("stall_valid", int'(s.out_valid), 1);
                chk("stall_data", int'(s.out_data), int'(held));
            end
            if (s.out_valid && s.out_ready) begin
                out_q.push_back(s.out_data);
                last_q.push_back(s.out_last);
                stalled = 1'b0;
            end else begin
                stalled = s.out_valid;
                held = s.out_data;
            end
            @(negedge clock);
            t++;
        end
        s.out_ready = 1'b0;
        if (busy) begin
            nchk++; nerr++;
            $display("FAIL drain_timeout: busy got 1 expected 0");
        end
        err_o = error;
    endtask

    task automatic check_result(input string tag, input bit abort,
                                input bit err_exp, input bit err_act);
        int n;
        chk({tag, "_len"}, out_q.size(), e_q.size());
        n = (out_q.size() < e_q.size()) ? out_q.size() : e_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, int'(out_q[i]), int'(e_q[i]));
            chk({tag, "_last"}, int'(last_q[i]), int'((i == e_q.size() - 1) && !abort));
        end
        chk({tag, "_error"}, int'(err_act), int'(err_exp));
        for (int i = 1; i < acc_q.size() && i < m_pops.size(); i++) begin
            chk({tag, "_gap"}, acc_q[i] - acc_q[i-1], 2 + m_pops[i-1]);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit e_dut;
        bit e_mod;
        int k;
        int len;
        int drop;
        int r;

        vt[0] = '{5'd2,  8'd13, 5'd15, 64'h8111_1111_1111_119, 5'd2,  64'h89,            1'b0, 2'd0, 1'b0};
        vt[1] = '{5'd2,  8'd13, 5'd15, 64'h2342_3423_4234_278, 5'd2,  64'h78,            1'b0, 2'd0, 1'b0};
        vt[2] = '{5'd12, 8'd3,  5'd15, 64'h9876_5432_1111_111, 5'd12, 64'h9876_5432_1111, 1'b0, 2'd0, 1'b0};
        vt[3] = '{5'd3,  8'd2,  5'd5,  64'h12345,              5'd3,  64'h345,           1'b0, 2'd0, 1'b0};
        vt[4] = '{5'd2,  8'd13, 5'd15, 64'h8111_1111_1111_119, 5'd2,  64'h89,            1'b0, 2'd2, 1'b0};
        vt[5] = '{5'd2,  8'd1,  5'd4,  64'h5432,               5'd1,  64'h5,             1'b1, 2'd0, 1'b1};
        vt[6] = '{5'd2,  8'd3,  5'd2,  64'h12,                 5'd1,  64'h2,             1'b1, 2'd0, 1'b0};
        vt[7] = '{5'd16, 8'd0,  5'd16, 64'hFEDC_BA98_7654_3210, 5'd16, 64'hFEDC_BA98_7654_3210, 1'b0, 2'd1, 1'b0};
        vt[8] = '{5'd1,  8'd4,  5'd5,  64'h3A5A2,              5'd1,  64'hA,             1'b0, 2'd1, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        keep_count = '0;
        drop_budget = '0;
        s.in_valid = 1'b0;
        s.in_data = 4'd0;
        s.in_last = 1'b0;
        s.out_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_in_ready", int'(s.in_ready), 0);
        chk("rst_out_valid", int'(s.out_valid), 0);
        chk("rst_out_last", int'(s.out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_error", int'(error), 0);

        // Illegal keep_count values: error, stay idle.
        foreach (vt[i]) begin end
        for (int b = 0; b < 2; b++) begin
            @(negedge clock);
            start = 1'b1;
            keep_count = (b == 0) ? SPW'(0) : SPW'(17);
            drop_budget = LW'(3);
            @(negedge clock);
            start = 1'b0;
            chk("badk_error", int'(error), 1);
            chk("badk_busy", int'(busy), 0);
            chk("badk_in_ready", int'(s.in_ready), 0);
        end

        for (int v = 0; v < 9; v++) begin
            in_q.delete();
            e_q.delete();
            for (int j = 0; j < int'(vt[v].len); j++)
                in_q.push_back(4'(vt[v].ins >> (4 * (int'(vt[v].len) - 1 - j))));
            for (int j = 0; j < int'(vt[v].olen); j++)
                e_q.push_back(4'(vt[v].outs >> (4 * (int'(vt[v].olen) - 1 - j))));
            model(int'(vt[v].k), int'(vt[v].drop), e_mod);
            run_stream(int'(vt[v].k), int'(vt[v].drop), int'(vt[v].rmode), vt[v].abort, e_dut);
            check_result($sformatf("vec%0d", v), vt[v].abort, vt[v].err, e_dut);
            if (!vt[v].abort) chk("vec_idle", int'(busy), 0);
        end

        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(1, 16);
            len = $urandom_range(1, 40);
            drop = (len > k) ? len - k : 0;
            r = $urandom_range(0, 3);
            if (r == 0) drop = drop + 1;
            else if (r == 1 && drop > 0) drop = drop - 1;
            in_q.delete();
            for (int j = 0; j < len; j++)
                in_q.push_back(4'($urandom_range(0, (it % 2 == 1) ? 3 : 15)));
            model(k, drop, e_mod);
            e_q = m_out;
            run_stream(k, drop, 1, 1'b0, e_dut);
            check_result($sformatf("rnd%0d", it), 1'b0, e_mod, e_dut);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
